// File: rtl/flash_pkg.sv
// flash_pkg: shared widths, FSM states and half-word select for the flash sample reader.
package flash_pkg;

   typedef enum logic [1:0] {IDLE, REQUEST, WAIT_DATA, DONE} state_t;

   localparam int FLASH_ADDR_W = 23;
   localparam int FLASH_DATA_W = 32;
   localparam int SAMPLE_W     = 16;
   localparam logic [3:0] BYTEENABLE_ALL = 4'b1111;

   function automatic logic [SAMPLE_W-1:0] pick_half(input logic [FLASH_DATA_W-1:0] word, input logic upper);
      return upper ? word[FLASH_DATA_W-1:SAMPLE_W] : word[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/flash_sample_reader_if.sv
// flash_sample_reader_if: Avalon-MM read-only flash port; master is the reader, slave is the flash.
interface flash_sample_reader_if;
   import flash_pkg::*;

   logic                    flash_mem_read;
   logic [FLASH_ADDR_W-1:0] flash_mem_address;
   logic [3:0]              flash_mem_byteenable;
   logic                    flash_mem_waitrequest;
   logic [FLASH_DATA_W-1:0] flash_mem_readdata;
   logic                    flash_mem_readdatavalid;

   modport master (
      output flash_mem_read, flash_mem_address, flash_mem_byteenable,
      input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid
   );

   modport slave (
      input  flash_mem_read, flash_mem_address, flash_mem_byteenable,
      output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid
   );

endinterface

// File: rtl/flash_sample_reader.sv
// flash_sample_reader: fetches one 16-bit sample from a 32-bit Avalon-MM flash word.
// Optional one-word cache enabled by defining FLASH_WORD_CACHE_EN.
module flash_sample_reader
   import flash_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                req_start,
   input  logic [23:0]         sample_addr,
   output logic                busy,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                sample_valid,
   flash_sample_reader_if.master flash
);

   state_t              r_state, w_next;
   logic [23:0]         r_addr;
   logic [SAMPLE_W-1:0] r_sample, w_hit_sample;
   logic                w_accept, w_capture, w_hit;

   assign w_accept = req_start && (r_state == IDLE || r_state == DONE);
   // data arriving on the same edge the read is accepted is taken straight away
   assign w_capture = flash.flash_mem_readdatavalid &&
                      (r_state == WAIT_DATA || (r_state == REQUEST && !flash.flash_mem_waitrequest));

`ifdef FLASH_WORD_CACHE_EN
   logic                    r_tag_valid;
   logic [FLASH_ADDR_W-1:0] r_tag;
   logic [FLASH_DATA_W-1:0] r_word;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_tag_valid <= 1'b0;
         r_tag       <= '0;
         r_word      <= '0;
      end else if (w_capture) begin
         r_tag_valid <= 1'b1;
         r_tag       <= r_addr[23:1];
         r_word      <= flash.flash_mem_readdata;
      end

   assign w_hit        = r_tag_valid && r_tag == sample_addr[23:1];
   assign w_hit_sample = pick_half(r_word, sample_addr[0]);
`else
   assign w_hit        = 1'b0;
   assign w_hit_sample = '0;
`endif

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_sample <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) r_addr <= sample_addr;
         if (w_capture) r_sample <= pick_half(flash.flash_mem_readdata, r_addr[0]);
         else if (w_accept && w_hit) r_sample <= w_hit_sample;
      end

   always_comb begin
      w_next               = r_state;
      busy                 = 1'b0;
      sample_valid         = 1'b0;
      flash.flash_mem_read = 1'b0;
      case (r_state)
         IDLE:      w_next = w_accept ? (w_hit ? DONE : REQUEST) : IDLE;
         REQUEST: begin
            busy                 = 1'b1;
            flash.flash_mem_read = 1'b1;
            w_next               = w_capture ? DONE : (flash.flash_mem_waitrequest ? REQUEST : WAIT_DATA);
         end
         WAIT_DATA: begin
            busy   = 1'b1;
            w_next = w_capture ? DONE : WAIT_DATA;
         end
         DONE: begin
            sample_valid = 1'b1;
            w_next       = w_accept ? (w_hit ? DONE : REQUEST) : IDLE;
         end
         default:   w_next = IDLE;
      endcase
   end

   assign sample_out                 = r_sample;
   assign flash.flash_mem_address    = r_addr[23:1];
   assign flash.flash_mem_byteenable = BYTEENABLE_ALL;

endmodule

// File: tb/tb_flash_sample_reader.sv
// tb_flash_sample_reader: vector table, hand-written corner sequences and random requests
// checked against a request-level model of the reader (and of the word cache when FLASH_WORD_CACHE_EN is defined).
module tb_flash_sample_reader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_start = 1'b0;
   logic [23:0] sample_addr = '0;
   logic        busy, sample_valid;
   logic [15:0] sample_out;

   int n_checks = 0;
   int n_fail = 0;

   logic        m_valid = 1'b0;
   logic [22:0] m_tag = '0;
   logic [31:0] m_word = '0;
   logic [15:0] m_sample = '0;

   flash_sample_reader_if bus();

   flash_sample_reader dut (
      .clk(clk), .reset(reset), .req_start(req_start), .sample_addr(sample_addr),
      .busy(busy), .sample_out(sample_out), .sample_valid(sample_valid), .flash(bus.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] addr;
      logic [31:0] data;
      int          waits;
      int          lat;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] half_of(input logic [31:0] w, input logic [23:0] a);
      return 16'((w >> (16 * int'(a[0]))) & 32'hFFFF);
   endfunction

   task automatic check_reset_state(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_valid"}, 32'(sample_valid), 32'd0);
      chk({tag, "_read"}, 32'(bus.flash_mem_read), 32'd0);
      chk({tag, "_addr"}, 32'(bus.flash_mem_address), 32'd0);
      chk({tag, "_sample"}, 32'(sample_out), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check_reset_state("rst");
      @(negedge clk);
      reset = 1'b0;
      m_valid = 1'b0;
      m_sample = '0;
   endtask

   // Starts at a negedge (IDLE or DONE) and returns at the negedge where sample_valid is expected.
   task automatic txn(input logic [23:0] a, input logic [31:0] d, input int waits, input int lat, input logic [15:0] exp);
      bit hit;
      logic [15:0] want;
      hit = 1'b0;
`ifdef FLASH_WORD_CACHE_EN
      hit = m_valid && m_tag == a[23:1];
`endif
      want = hit ? half_of(m_word, a) : exp;
      req_start = 1'b1;
      sample_addr = a;
      @(negedge clk);
      req_start = 1'b0;
      sample_addr = $urandom;
      if (!hit) begin
         for (int i = 0; i <= waits; i++) begin
            bus.flash_mem_waitrequest = (i < waits);
            if (i == waits && lat == 0) begin
               bus.flash_mem_readdatavalid = 1'b1;
               bus.flash_mem_readdata = d;
            end
            chk("req_read", 32'(bus.flash_mem_read), 32'd1);
            chk("req_addr", 32'(bus.flash_mem_address), 32'(a >> 1));
            chk("req_busy", 32'(busy), 32'd1);
            chk("req_valid", 32'(sample_valid), 32'd0);
            @(negedge clk);
         end
         bus.flash_mem_waitrequest = 1'b0;
         bus.flash_mem_readdatavalid = 1'b0;
         if (lat > 0) begin
            for (int i = 1; i < lat; i++) begin
               chk("wait_read", 32'(bus.flash_mem_read), 32'd0);
               chk("wait_valid", 32'(sample_valid), 32'd0);
               chk("wait_hold", 32'(sample_out), 32'(m_sample));
               @(negedge clk);
            end
            bus.flash_mem_readdatavalid = 1'b1;
            bus.flash_mem_readdata = d;
            @(negedge clk);
            bus.flash_mem_readdatavalid = 1'b0;
            bus.flash_mem_readdata = $urandom;
         end
         m_valid = 1'b1;
         m_tag = a[23:1];
         m_word = d;
      end
      chk("done_valid", 32'(sample_valid), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_read", 32'(bus.flash_mem_read), 32'd0);
      chk("done_sample", 32'(sample_out), 32'(want));
      m_sample = want;
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(sample_valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_hold"}, 32'(sample_out), 32'(m_sample));
   endtask

   initial begin
      bus.flash_mem_waitrequest = 1'b0;
      bus.flash_mem_readdata = '0;
      bus.flash_mem_readdatavalid = 1'b0;

      tbl[0] = '{24'd59072,    32'hA5A51234, 0, 1, 16'h1234};
      tbl[1] = '{24'h000100,   32'h01020304, 0, 2, 16'h0304};
      tbl[2] = '{24'd59073,    32'hBEEF0F0F, 3, 1, 16'hBEEF};
      tbl[3] = '{24'hFFFFFF,   32'h89ABCDEF, 1, 0, 16'h89AB};
      tbl[4] = '{24'h000000,   32'h0000FFFF, 0, 3, 16'hFFFF};
      tbl[5] = '{24'h123457,   32'hCAFE5555, 2, 0, 16'hCAFE};

      repeat (2) @(negedge clk);
      check_reset_state("init");
      chk("init_be", 32'(bus.flash_mem_byteenable), 32'hF);
      reset = 1'b0;
      @(negedge clk);

      foreach (tbl[k]) begin
         txn(tbl[k].addr, tbl[k].data, tbl[k].waits, tbl[k].lat, tbl[k].exp);
         idle_check("tbl_idle");
      end

      // back-to-back: second request issued while DONE is showing the first result
      do_reset();
      txn(24'd59072, 32'hA5A51234, 0, 1, 16'h1234);
      txn(24'd59100, 32'h7777AAAA, 0, 1, 16'hAAAA);
      idle_check("b2b_idle");

      // req_start while waiting for data must not disturb the latched address
      do_reset();
      req_start = 1'b1;
      sample_addr = 24'd59072;
      @(negedge clk);
      req_start = 1'b0;
      @(negedge clk);
      req_start = 1'b1;
      sample_addr = 24'd100;
      @(negedge clk);
      req_start = 1'b0;
      chk("ign_addr", 32'(bus.flash_mem_address), 32'd29536);
      chk("ign_busy", 32'(busy), 32'd1);
      chk("ign_valid", 32'(sample_valid), 32'd0);
      bus.flash_mem_readdatavalid = 1'b1;
      bus.flash_mem_readdata = 32'hA5A51234;
      @(negedge clk);
      bus.flash_mem_readdatavalid = 1'b0;
      chk("ign_done", 32'(sample_valid), 32'd1);
      chk("ign_sample", 32'(sample_out), 32'h1234);
      m_sample = 16'h1234;
      m_valid = 1'b1;
      m_tag = 23'd29536;
      m_word = 32'hA5A51234;
      @(negedge clk);
      chk("ign_single", 32'(sample_valid), 32'd0);
      bus.flash_mem_readdatavalid = 1'b1;
      bus.flash_mem_readdata = 32'h55554444;
      @(negedge clk);
      bus.flash_mem_readdatavalid = 1'b0;
      chk("stray_valid", 32'(sample_valid), 32'd0);
      chk("stray_sample", 32'(sample_out), 32'h1234);

      // reset in WAIT_DATA, then a late readdatavalid
      do_reset();
      req_start = 1'b1;
      sample_addr = 24'd59072;
      @(negedge clk);
      req_start = 1'b0;
      @(negedge clk);
      chk("mid_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check_reset_state("mid_rst");
      @(negedge clk);
      reset = 1'b0;
      m_valid = 1'b0;
      m_sample = '0;
      bus.flash_mem_readdatavalid = 1'b1;
      bus.flash_mem_readdata = 32'hA5A51234;
      @(negedge clk);
      bus.flash_mem_readdatavalid = 1'b0;
      chk("late_valid", 32'(sample_valid), 32'd0);
      chk("late_sample", 32'(sample_out), 32'd0);
      chk("late_read", 32'(bus.flash_mem_read), 32'd0);

      // same word, other half: served from cache when enabled, otherwise a second read
      do_reset();
      txn(24'd59072, 32'hA5A51234, 0, 1, 16'h1234);
      idle_check("c_idle");
      txn(24'd59073, 32'hDEAD0000, 0, 1, 16'hDEAD);
`ifdef FLASH_WORD_CACHE_EN
      chk("cache_hit", 32'(sample_out), 32'hA5A5);
`else
      chk("cache_off", 32'(sample_out), 32'hDEAD);
`endif
      idle_check("c_idle2");

      for (int r = 0; r < 40; r++) begin
         logic [23:0] a;
         logic [31:0] d;
         a = ($urandom_range(0, 2) == 0) ? {m_tag, 1'($urandom)} : 24'($urandom);
         d = $urandom;
         txn(a, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), half_of(d, a));
         repeat ($urandom_range(0, 2)) idle_check("rnd_idle");
      end
      idle_check("final_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
